// File: rtl/operand_src_sel_if.sv
// operand_src_sel_if
//   Bundles the operand-request handshake, the EX/MEM forwarding candidates
//   and the registered result handshake of operand_src_sel.
//   master : upstream/downstream side (drives requests, out_ready)
//   slave  : operand_src_sel itself
// Signals:
//   in_valid/in_ready           request handshake (in_ready is registered)
//   in_sel, in_data             candidate index and packed candidates
//   in_rs, in_imm_sext          candidate-0 register address, immediate sign mode
//   fwd_ex_*, fwd_mem_*         writeback candidates for forwarding
//   out_valid/out_ready         result handshake
//   out_data, out_fwd, sel_err  result operand, source tag, bad-index pulse
interface operand_src_sel_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int ADDR_W  = 5
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          in_sel;
    logic [NUM_SRC*DATA_W-1:0] in_data;
    logic [ADDR_W-1:0]         in_rs;
    logic                      in_imm_sext;
    logic                      fwd_ex_valid;
    logic [ADDR_W-1:0]         fwd_ex_rd;
    logic [DATA_W-1:0]         fwd_ex_data;
    logic                      fwd_mem_valid;
    logic [ADDR_W-1:0]         fwd_mem_rd;
    logic [DATA_W-1:0]         fwd_mem_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [1:0]                out_fwd;
    logic                      sel_err;

    modport master (
        output in_valid, in_sel, in_data, in_rs, in_imm_sext,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_mem_valid, fwd_mem_rd, fwd_mem_data, out_ready,
        input  in_ready, out_valid, out_data, out_fwd, sel_err
    );

    modport slave (
        input  in_valid, in_sel, in_data, in_rs, in_imm_sext,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_mem_valid, fwd_mem_rd, fwd_mem_data, out_ready,
        output in_ready, out_valid, out_data, out_fwd, sel_err
    );
endinterface

// File: rtl/operand_src_sel.sv
// operand_src_sel
//   Registered EX-stage operand source selector. Chooses one of NUM_SRC
//   candidates (0 = register file with EX/MEM forwarding, NUM_SRC-1 =
//   immediate with sign/zero extension) and delivers it through a
//   valid/ready stage with a one-entry skid buffer, so in_ready is a flop.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  operand_src_sel_if.slave (request, forwarding and result signals)
module operand_src_sel #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int ADDR_W  = 5,
    parameter int IMM_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    operand_src_sel_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_SRC);
    // Bits above the immediate field; filled with the sign bit or zeros.
    localparam logic [DATA_W-1:0] HI_MASK = ~DATA_W'((64'd1 << IMM_W) - 64'd1);

    logic [SEL_W-1:0]  w_sel_raw;
    logic [31:0]       w_sel;
    logic [ADDR_W-1:0] w_rs;
    logic [DATA_W-1:0] w_imm_cand;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_data;
    logic [1:0]        w_fwd;
    logic              w_err;
    logic              w_accept;
    logic              w_main_free;
    logic              w_skid_next;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [1:0]        r_out_fwd;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [1:0]        r_skid_fwd;
    logic              r_in_ready;
    logic              r_sel_err;

    assign w_sel_raw  = bus.in_sel;
    assign w_sel      = 32'(w_sel_raw);
    assign w_rs       = bus.in_rs;
    assign w_imm_cand = bus.in_data[(NUM_SRC-1)*DATA_W +: DATA_W];
    assign w_imm      = (w_imm_cand & ~HI_MASK) |
                        ((bus.in_imm_sext && w_imm_cand[IMM_W-1]) ? HI_MASK : '0);

    always_comb begin
        w_data = '0;
        w_fwd  = 2'b00;
        w_err  = 1'b0;
        if (w_sel == 32'd0) begin
            // EX is the younger writer, so it wins over MEM.
            if (bus.fwd_ex_valid && (bus.fwd_ex_rd == w_rs)) begin
                w_data = bus.fwd_ex_data;
                w_fwd  = 2'b01;
            end else if (bus.fwd_mem_valid && (bus.fwd_mem_rd == w_rs)) begin
                w_data = bus.fwd_mem_data;
                w_fwd  = 2'b10;
            end else begin
                w_data = bus.in_data[0 +: DATA_W];
            end
        end else if (w_sel == 32'(NUM_SRC - 1)) begin
            w_data = w_imm;
        end else if (w_sel >= 32'(NUM_SRC)) begin
            w_err = 1'b1;
        end else begin
            for (int unsigned k = 1; k < NUM_SRC - 1; k++) begin
                if (w_sel == k) begin
                    w_data = bus.in_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_main_free = !r_out_valid || bus.out_ready;
    // Skid empties whenever main frees up (its entry moves over); otherwise
    // it fills on an accept that main cannot take.
    assign w_skid_next = w_main_free ? 1'b0 : (r_skid_valid || w_accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_fwd    <= 2'b00;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_fwd   <= 2'b00;
            r_in_ready   <= 1'b1;
            r_sel_err    <= 1'b0;
        end else begin
            r_sel_err <= w_accept && w_err;
            if (w_main_free) begin
                // A full skid implies in_ready is low, so no accept collides here.
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_fwd    <= r_skid_fwd;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_accept;
                    if (w_accept) begin
                        r_out_data <= w_data;
                        r_out_fwd  <= w_fwd;
                    end
                end
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_data;
                r_skid_fwd   <= w_fwd;
            end
            r_in_ready <= !w_skid_next;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_fwd   = r_out_fwd;
    assign bus.sel_err   = r_sel_err;
endmodule

// File: doc/operand_src_sel.md
# operand_src_sel

Parametrised, registered operand source selector for the EX stage. Picks one of `NUM_SRC` operand candidates, applies EX/MEM forwarding to the register-file candidate and sign/zero extension to the immediate candidate, and delivers the result through a valid/ready pipeline stage with a one-entry skid buffer so `in_ready` is a flop output. Sits between the ID/EX operand-collection logic and the ALU/move datapath, as the successor of the fixed 2:1 move-source mux.

## Interface

- `DATA_W`, 32: operand width.
- `NUM_SRC`, 4: candidate count, ≥2. Index 0 is the register-file read, and index `NUM_SRC-1` is the immediate.
- `ADDR_W`, 5: register address width.
- `IMM_W`, 16: immediate width, ≤`DATA_W`.
- `SEL_W`, `$clog2(NUM_SRC)`: derived; do not override.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream has an operand request.
- `in_ready`  out  1  block can accept; registered.
- `in_sel`  in  `SEL_W`  candidate index.
- `in_data`  in  `NUM_SRC*DATA_W`  candidates; candidate k is `[k*DATA_W +: DATA_W]`.
- `in_rs`  in  `ADDR_W`  source register address of candidate 0.
- `in_imm_sext`  in  1  1 = sign-extend the immediate, 0 = zero-extend it.
- `fwd_ex_valid`, `fwd_ex_rd`, `fwd_ex_data`  in  1/`ADDR_W`/`DATA_W`  EX-stage writeback candidate.
- `fwd_mem_valid`, `fwd_mem_rd`, `fwd_mem_data`  in  1/`ADDR_W`/`DATA_W`  MEM-stage writeback candidate.
- `out_valid`  out  1  operand available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  `DATA_W`  selected operand.
- `out_fwd`  out  2  operand source tag: 00 = no forwarding, 01 = EX, 10 = MEM.
- `sel_err`  out  1  one-cycle pulse when an accepted request had `in_sel ≥ NUM_SRC`.

## Operation

- **Accept.** A request is accepted on a rising edge when `in_valid && in_ready`. The value is computed combinationally from the inputs in that cycle and captured.
- **Value selection**, in priority order:
  - If `in_sel == 0` and `fwd_ex_valid` and `fwd_ex_rd == in_rs`: take `fwd_ex_data`, tag 01.
  - Else, if `in_sel == 0` and `fwd_mem_valid` and `fwd_mem_rd == in_rs`: take `fwd_mem_data`, tag 10.
  - Else, if `in_sel == 0`: take candidate 0, tag 00.
  - If `in_sel == NUM_SRC-1`: take the low `IMM_W` bits of that candidate, extended per `in_imm_sext`. Tag 00.
  - Other indices below `NUM_SRC`: candidate passes unchanged, tag 00.
  - `in_sel ≥ NUM_SRC` (non-power-of-2 `NUM_SRC`): data = 0, tag 00, and `sel_err` pulses the cycle after acceptance.
- **Forwarding scope.** Forwarding applies only to index 0. Address 0 is not special; it forwards like any other address.
- **Storage.** Two registers hold accepted results: the main output register (`out_*`) and a skid register.
  - Accept while the main register is empty or draining (`!out_valid || out_ready`): the result goes to the main register.
  - Accept otherwise: the result goes to the skid register.
  - When the main register drains and the skid register is full: skid moves to main the same edge, and a simultaneous new accept is impossible because `in_ready` = 0.
- **Ready.** `in_ready` next = !(skid full after this edge).
- **Ordering.** Results leave in acceptance order; no reordering or dropping.
- **Stability.** `out_data`/`out_fwd` stay stable while `out_valid && !out_ready`.
- **Reset.** `rst` asserted at any time, including mid-transfer, clears both entries immediately. `out_valid` = 0, `out_data` = 0, `out_fwd` = 00, `sel_err` = 0, `in_ready` = 1. In-flight operands are discarded.

## Timing

- Latency: accept at edge N gives `out_valid` = 1 after edge N; the operand is visible in cycle N+1.
- Throughput: 1 per cycle while `out_ready` = 1.
- Capacity: 2 entries (main + skid).
- Ready behaviour: `in_ready` falls the cycle after the skid register fills and rises the cycle after it drains.
- Forwarding inputs are sampled only in the accept cycle. Later changes do not alter a captured operand.
- `sel_err` is registered and high for exactly one cycle per bad accept.
- No combinational path from `out_ready` to `in_ready`.

## Test plan

- **Forward priority.** `in_sel` = 0, `in_rs` = 7, EX and MEM both valid with rd = 7, data 0xAAAA_0001 and 0xBBBB_0002. Required: `out_data` = 0xAAAA_0001, `out_fwd` = 01. With EX rd = 6 instead: 0xBBBB_0002, tag 10. With neither matching: candidate 0, tag 00.
- **Immediate extension.** `in_sel` = 3, immediate slot = 0x0000_8001. `in_imm_sext` = 1 gives `out_data` = 0xFFFF_8001; `in_imm_sext` = 0 gives 0x0000_8001.
- **Backpressure.** Accept 3 back-to-back requests (values 1, 2, 3) with `out_ready` = 0. Required: values 1 and 2 accepted, `in_ready` = 0 before value 3 is taken. Then hold `out_ready` = 1: outputs 1, 2, 3 in order, no loss, `out_data` stable while stalled.
- **Streaming.** 100 random requests with `out_ready` = 1 continuously. Required: one output per cycle, latency 1, outputs match a reference model.
- **Bad select.** `NUM_SRC` = 3, `in_sel` = 3 accepted. Required: `out_data` = 0, `sel_err` high exactly 1 cycle.
- **Mid-operation reset.** With both entries full, assert `rst` asynchronously mid-cycle. Required: `out_valid` = 0, `in_ready` = 1 immediately. After release, the first accepted request appears alone.
